// File: rtl/text_vram_chargen_if.sv
// text_vram_chargen_if: character-buffer write port, raster read/pixel-position inputs, and the code/pixel outputs.
//   wr_en/wr_addr/wr_data : buffer write strobe, address and code (master -> slave)
//   rd_addr, pix_x, pix_y : raster read address and pixel position in the cell (master -> slave)
//   char_code, pixel      : registered code and glyph bit (slave -> master)
interface text_vram_chargen_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        pix_x;
  logic [3:0]        pix_y;
  logic [DATA_W-1:0] char_code;
  logic              pixel;
  modport master (output wr_en, wr_addr, wr_data, rd_addr, pix_x, pix_y, input char_code, pixel);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, pix_x, pix_y, output char_code, pixel);
endinterface

// File: rtl/text_vram_chargen.sv
// text_vram_chargen: 4096x8 text buffer with a two-stage read pipeline feeding an 8x8 (doubled to 16x16) glyph ROM.
//   clk_50mhz : sole clock
//   rst_n     : asynchronous active-low reset (clears pipeline, not the buffer)
//   bus       : slave side of text_vram_chargen_if (write port, raster read, char_code/pixel outputs)
module text_vram_chargen #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  text_vram_chargen_if.slave bus
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W] = '{default: '0};
  logic [DATA_W-1:0] r_code;
  logic [2:0]        r_px;
  logic [2:0]        r_py;
  logic              r_pix;
  logic [63:0]       w_glyph;
  logic [5:0]        w_idx;
  logic              w_unused;
  // Glyph rows packed top row first: row r occupies bits [63-8r -: 8], bit 7 of each row is leftmost.
  function automatic logic [63:0] glyph(input logic [7:0] c);
    case (c)
      8'h00, 8'h20: glyph = 64'h0000000000000000;
      8'h30:        glyph = 64'h7CC6CEDEF6E67C00;
      8'h31:        glyph = 64'h307030303030FC00;
      8'h32:        glyph = 64'h78CC0C3860CCFC00;
      8'h33:        glyph = 64'h78CC0C380CCC7800;
      8'h34:        glyph = 64'h1C3C6CCCFE0C1E00;
      8'h35:        glyph = 64'hFCC0F80C0CCC7800;
      8'h36:        glyph = 64'h3860C0F8CCCC7800;
      8'h37:        glyph = 64'hFCCC0C1830303000;
      8'h38:        glyph = 64'h78CCCC78CCCC7800;
      8'h39:        glyph = 64'h78CCCC7C0C187000;
      8'h41:        glyph = 64'h3078CCCCFCCCCC00;
      8'h42:        glyph = 64'hFC66667C6666FC00;
      8'h43:        glyph = 64'h3C66C0C0C0663C00;
      8'h44:        glyph = 64'hF86C6666666CF800;
      8'h45:        glyph = 64'hFE6268786862FE00;
      8'h46:        glyph = 64'hFE6268786860F000;
      default:      glyph = 64'hFF818181818181FF;
    endcase
  endfunction
  always_ff @(posedge clk_50mhz)
    if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
  // Reading the array in the same edge as the write gives read-first behaviour on address collisions.
  always_ff @(posedge clk_50mhz or negedge rst_n)
    if (!rst_n) begin
      r_code <= '0;
      r_px   <= '0;
      r_py   <= '0;
      r_pix  <= 1'b0;
    end else begin
      r_code <= r_mem[bus.rd_addr];
      r_px   <= bus.pix_x[3:1];
      r_py   <= bus.pix_y[3:1];
      r_pix  <= w_glyph[w_idx];
    end
  // 63 - (8*row + col) folds to a bitwise inversion of {row,col}.
  assign w_glyph       = glyph(r_code);
  assign w_idx         = ~{r_py, r_px};
  assign w_unused      = ^{bus.pix_x[0], bus.pix_y[0]};
  assign bus.char_code = r_code;
  assign bus.pixel     = r_pix;
endmodule

// File: tb/tb_text_vram_chargen.sv
// tb_text_vram_chargen: randomized and directed checks of text_vram_chargen against an array/table reference model.
module tb_text_vram_chargen;
  logic clk_50mhz = 1'b0;
  logic rst_n;
  always #10 clk_50mhz = ~clk_50mhz;
  text_vram_chargen_if bus();
  text_vram_chargen dut (.clk_50mhz(clk_50mhz), .rst_n(rst_n), .bus(bus));
  logic [7:0]  mmem [4096];
  logic [63:0] fnt  [256];
  logic [7:0]  picks [17] = '{8'h00, 8'h20, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                              8'h37, 8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
  int vecs = 0;
  int errs = 0;
  logic exp_pix_next;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic fbit(input logic [7:0] c, input logic [3:0] px, input logic [3:0] py);
    int row;
    int col;
    row = int'(py) / 2;
    col = int'(px) / 2;
    return fnt[c][63 - 8 * row - col];
  endfunction
  function automatic logic [7:0] pick();
    return ($urandom_range(0, 3) == 0) ? 8'($urandom) : picks[$urandom_range(0, 16)];
  endfunction
  task automatic cyc(input logic we, input logic [11:0] wa, input logic [7:0] wd,
                     input logic [11:0] ra, input logic [3:0] px, input logic [3:0] py, input string tag);
    logic [7:0] ec;
    logic ep;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_addr = ra; bus.pix_x = px; bus.pix_y = py;
    ec = mmem[ra];
    ep = fbit(ec, px, py);
    @(posedge clk_50mhz);
    if (we) mmem[wa] = wd;
    #1;
    chk({tag, "_code"}, bus.char_code, ec);
    chk({tag, "_pix"}, {7'b0, bus.pixel}, {7'b0, exp_pix_next});
    exp_pix_next = ep;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mmem[i] = 8'h00;
    for (int i = 0; i < 256; i++) fnt[i] = 64'hFF818181818181FF;
    fnt[8'h00] = 64'h0000000000000000; fnt[8'h20] = 64'h0000000000000000;
    fnt[8'h30] = 64'h7CC6CEDEF6E67C00; fnt[8'h31] = 64'h307030303030FC00;
    fnt[8'h32] = 64'h78CC0C3860CCFC00; fnt[8'h33] = 64'h78CC0C380CCC7800;
    fnt[8'h34] = 64'h1C3C6CCCFE0C1E00; fnt[8'h35] = 64'hFCC0F80C0CCC7800;
    fnt[8'h36] = 64'h3860C0F8CCCC7800; fnt[8'h37] = 64'hFCCC0C1830303000;
    fnt[8'h38] = 64'h78CCCC78CCCC7800; fnt[8'h39] = 64'h78CCCC7C0C187000;
    fnt[8'h41] = 64'h3078CCCCFCCCCC00; fnt[8'h42] = 64'hFC66667C6666FC00;
    fnt[8'h43] = 64'h3C66C0C0C0663C00; fnt[8'h44] = 64'hF86C6666666CF800;
    fnt[8'h45] = 64'hFE6268786862FE00; fnt[8'h46] = 64'hFE6268786860F000;
    rst_n = 1'b0;
    exp_pix_next = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 12'($urandom); bus.pix_x = 4'($urandom); bus.pix_y = 4'($urandom);
      @(posedge clk_50mhz);
      #1;
      chk("rst_code", bus.char_code, 8'h00);
      chk("rst_pix", {7'b0, bus.pixel}, 8'h00);
    end
    rst_n = 1'b1;
    cyc(0, 12'h000, 8'h00, 12'h000, 4'd0, 4'd0, "rd0");
    cyc(1, 12'h005, 8'h41, 12'h000, 4'd0, 4'd0, "wrA");
    for (int y = 0; y < 16; y++) cyc(0, 12'h000, 8'h00, 12'h005, 4'd4, 4'(y), "A_col");
    cyc(1, 12'h020, 8'h30, 12'h005, 4'd0, 4'd0, "wr0");
    for (int x = 0; x < 16; x++) cyc(0, 12'h000, 8'h00, 12'h020, 4'(x), 4'd6, "zero_row3");
    cyc(1, 12'h050, 8'h7F, 12'h020, 4'd0, 4'd0, "wrbox");
    for (int x = 0; x < 16; x++) cyc(0, 12'h000, 8'h00, 12'h050, 4'(x), 4'd0, "box_top");
    for (int x = 0; x < 16; x++) cyc(0, 12'h000, 8'h00, 12'h050, 4'(x), 4'd4, "box_mid");
    cyc(1, 12'h100, 8'h31, 12'h000, 4'd0, 4'd0, "wr31");
    cyc(1, 12'h100, 8'h32, 12'h100, 4'd2, 4'd2, "rdw_old");
    cyc(0, 12'h000, 8'h00, 12'h100, 4'd2, 4'd2, "rdw_new");
    cyc(1, 12'hFFF, 8'h39, 12'h100, 4'd0, 4'd0, "wrFFF");
    cyc(1, 12'h000, 8'h46, 12'hFFF, 4'd0, 4'd0, "wr000");
    for (int i = 0; i < 12; i++)
      cyc(0, 12'h000, 8'h00, i[0] ? 12'h000 : 12'hFFF, 4'($urandom), 4'($urandom), "wrap");
    @(negedge clk_50mhz);
    rst_n = 1'b0;
    #1;
    chk("async_rst_code", bus.char_code, 8'h00);
    chk("async_rst_pix", {7'b0, bus.pixel}, 8'h00);
    @(posedge clk_50mhz);
    #1;
    chk("held_rst_code", bus.char_code, 8'h00);
    rst_n = 1'b1;
    exp_pix_next = 1'b0;
    cyc(0, 12'h000, 8'h00, 12'h005, 4'd0, 4'd2, "post_rst");
    cyc(0, 12'h000, 8'h00, 12'h020, 4'd0, 4'd2, "post_rst");
    for (int i = 0; i < 500; i++) begin
      logic [11:0] wa;
      logic [11:0] ra;
      wa = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 7)) : 12'(12'hFFC + 12'($urandom_range(0, 3)));
      ra = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 7)) : 12'(12'hFFC + 12'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) ra = wa;
      cyc(1'($urandom), wa, pick(), ra, 4'($urandom), 4'($urandom), "rand");
    end
    cyc(0, 12'h000, 8'h00, 12'h000, 4'd0, 4'd0, "flush");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
